// File: rtl/ras_stack.sv
// Return address stack for fetch stage F1 with BOB checkpoint/restore.
// Define RAS_REPAIR_EN to also rewrite the TOS entry on restore.
module ras_stack #(
  parameter int DEPTH    = 16,
  parameter int LOGDEPTH = 4,
  parameter int ADDRW    = 64
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                push_f1_i,
  input  logic [ADDRW-1:0]    ret_addr_f1_i,
  input  logic                pop_f1_i,
  input  logic                restore_i,
  input  logic [LOGDEPTH-1:0] restore_ptr_i,
  input  logic [ADDRW-1:0]    restore_top_i,
  output logic [LOGDEPTH-1:0] ras_ptr_o,
  output logic [ADDRW-1:0]    ras_top_o,
  output logic                ras_valid_o
);

  logic [LOGDEPTH-1:0] ptr;
  logic [LOGDEPTH-1:0] ptr_nxt;
  logic [ADDRW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0]    vld;

  logic                wr_en;
  logic [LOGDEPTH-1:0] wr_idx;
  logic [ADDRW-1:0]    wr_data;

  logic do_rst;
  logic do_pp;
  logic do_push;
  logic do_pop;

  assign do_rst  = restore_i;
  assign do_pp   = !restore_i && push_f1_i && pop_f1_i;
  assign do_push = !restore_i && push_f1_i && !pop_f1_i;
  assign do_pop  = !restore_i && !push_f1_i && pop_f1_i;

`ifndef RAS_REPAIR_EN
  logic unused_top;
  assign unused_top = ^restore_top_i;
`endif

  // Select next pointer and the single entry written this cycle
  always_comb begin
    ptr_nxt = ptr;
    wr_en   = 1'b0;
    wr_idx  = ptr;
    wr_data = ret_addr_f1_i;
    unique case (1'b1)
      do_rst: begin
        ptr_nxt = restore_ptr_i;
`ifdef RAS_REPAIR_EN
        wr_en   = 1'b1;
        wr_idx  = restore_ptr_i;
        wr_data = restore_top_i;
`endif
      end
      do_pp: begin
        wr_en = 1'b1;
      end
      do_push: begin
        ptr_nxt = ptr + 1'b1;
        wr_en   = 1'b1;
        wr_idx  = ptr + 1'b1;
      end
      do_pop: begin
        ptr_nxt = ptr - 1'b1;
      end
      default: begin
        ptr_nxt = ptr;
      end
    endcase
  end

  // Pointer and valid bits
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
      vld <= '0;
    end else begin
      ptr <= ptr_nxt;
      if (wr_en) vld[wr_idx] <= 1'b1;
    end
  end

  // Return address storage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign ras_ptr_o   = ptr;
  assign ras_top_o   = mem[ptr];
  assign ras_valid_o = vld[ptr];

endmodule

// File: tb/tb_ras_stack.sv
// Self-checking bench for ras_stack: directed scenarios plus random traffic
// compared against a plain-array stack model.
module tb_ras_stack;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        push_f1_i = 1'b0;
  logic [63:0] ret_addr_f1_i = '0;
  logic        pop_f1_i = 1'b0;
  logic        restore_i = 1'b0;
  logic [3:0]  restore_ptr_i = '0;
  logic [63:0] restore_top_i = '0;
  logic [3:0]  ras_ptr_o;
  logic [63:0] ras_top_o;
  logic        ras_valid_o;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] m_mem [16];
  bit          m_vld [16];
  int          m_ptr;

  ras_stack dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .push_f1_i     (push_f1_i),
    .ret_addr_f1_i (ret_addr_f1_i),
    .pop_f1_i      (pop_f1_i),
    .restore_i     (restore_i),
    .restore_ptr_i (restore_ptr_i),
    .restore_top_i (restore_top_i),
    .ras_ptr_o     (ras_ptr_o),
    .ras_top_o     (ras_top_o),
    .ras_valid_o   (ras_valid_o)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0;
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = '0;
      m_vld[i] = 1'b0;
    end
  endfunction

  function automatic void model_step(input bit pu, input bit po,
                                     input logic [63:0] a, input bit rs,
                                     input int rp, input logic [63:0] rt);
    if (rs) begin
      m_ptr = rp;
`ifdef RAS_REPAIR_EN
      m_mem[rp] = rt;
      m_vld[rp] = 1'b1;
`endif
    end else if (pu && po) begin
      m_mem[m_ptr] = a;
      m_vld[m_ptr] = 1'b1;
    end else if (pu) begin
      m_ptr = (m_ptr + 1) % 16;
      m_mem[m_ptr] = a;
      m_vld[m_ptr] = 1'b1;
    end else if (po) begin
      m_ptr = (m_ptr + 15) % 16;
    end
  endfunction

  task automatic compare(input string tag);
    check_eq({tag, "_ptr"}, {60'b0, ras_ptr_o}, 64'(m_ptr));
    check_eq({tag, "_top"}, ras_top_o, m_mem[m_ptr]);
    check_eq({tag, "_vld"}, {63'b0, ras_valid_o}, {63'b0, m_vld[m_ptr]});
  endtask

  task automatic step(input bit pu, input bit po, input logic [63:0] a,
                      input bit rs, input int rp, input logic [63:0] rt,
                      input string tag);
    push_f1_i     = pu;
    pop_f1_i      = po;
    ret_addr_f1_i = a;
    restore_i     = rs;
    restore_ptr_i = 4'(rp);
    restore_top_i = rt;
    @(posedge clock);
    model_step(pu, po, a, rs, rp, rt);
    #1;
    compare(tag);
    push_f1_i = 1'b0;
    pop_f1_i  = 1'b0;
    restore_i = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #2;
    model_reset();
    compare(tag);
    check_eq({tag, "_k0"}, {60'b0, ras_ptr_o}, 64'd0);
    check_eq({tag, "_k1"}, ras_top_o, 64'd0);
    check_eq({tag, "_k2"}, {63'b0, ras_valid_o}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit pu, po, rs;
    int rp;
    logic [63:0] a, rt;

    model_reset();
    do_reset("t1");

    step(1, 0, 64'h100, 0, 0, 0, "t2a");
    step(1, 0, 64'h200, 0, 0, 0, "t2b");
    check_eq("t2_ptr2", {60'b0, ras_ptr_o}, 64'd2);
    check_eq("t2_top200", ras_top_o, 64'h200);
    step(0, 1, 0, 0, 0, 0, "t2c");
    check_eq("t2_ptr1", {60'b0, ras_ptr_o}, 64'd1);
    check_eq("t2_top100", ras_top_o, 64'h100);
    check_eq("t2_vld", {63'b0, ras_valid_o}, 64'd1);

    do_reset("t3r");
    for (int i = 0; i < 17; i++)
      step(1, 0, 64'h1000 + 64'(4 * i), 0, 0, 0, "t3p");
    check_eq("t3_ptr_ovf", {60'b0, ras_ptr_o}, 64'd1);
    check_eq("t3_top_ovf", ras_top_o, 64'h1040);
    for (int i = 0; i < 16; i++)
      step(0, 1, 0, 0, 0, 0, "t3q");
    check_eq("t3_ptr_pop", {60'b0, ras_ptr_o}, 64'd1);
    check_eq("t3_top_pop", ras_top_o, 64'h1040);

    do_reset("t4r");
    step(1, 0, 64'h80, 0, 0, 0, "t4a");
    step(1, 0, 64'h90, 0, 0, 0, "t4b");
    step(1, 0, 64'hA0, 0, 0, 0, "t4c");
    step(1, 1, 64'hB0, 0, 0, 0, "t4d");
    check_eq("t4_ptr", {60'b0, ras_ptr_o}, 64'd3);
    check_eq("t4_top", ras_top_o, 64'hB0);

    step(1, 0, 64'hD0, 0, 0, 0, "t5a");
    step(1, 0, 64'hE0, 0, 0, 0, "t5b");
    step(1, 0, 64'hDEAD, 1, 2, 64'h90, "t5c");
    check_eq("t5_ptr", {60'b0, ras_ptr_o}, 64'd2);
    step(0, 0, 0, 1, 7, 64'h77, "t5d");
    step(0, 1, 0, 0, 0, 0, "t5e");
    check_eq("t5_m6_top", ras_top_o, 64'd0);
    check_eq("t5_m6_vld", {63'b0, ras_valid_o}, 64'd0);

    step(0, 0, 0, 1, 2, 64'h90, "t6a");
    step(1, 0, 64'hBAD, 0, 0, 0, "t6b");
    step(0, 0, 0, 1, 3, 64'hC0, "t6c");
`ifdef RAS_REPAIR_EN
    check_eq("t6_top", ras_top_o, 64'hC0);
`else
    check_eq("t6_top", ras_top_o, 64'hBAD);
`endif

    reset_n = 1'b0;
    #2;
    model_reset();
    compare("async");
    @(negedge clock);
    reset_n = 1'b1;
    #1;

    for (int n = 0; n < 600; n++) begin
      pu = ($urandom_range(0, 2) != 0);
      po = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 7) == 0);
      rp = int'($urandom_range(0, 15));
      a  = {$urandom, $urandom};
      rt = {$urandom, $urandom};
      if (n % 100 > 60) begin
        pu = ($urandom_range(0, 3) == 0);
        po = ($urandom_range(0, 3) != 0);
      end
      step(pu, po, a, rs, rp, rt, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
